bcd_updown_counter_chain: RTL and testbench
===========================================

// Module: bcd_updown_counter_chain
// PURPOSE
//   Parametrised multi-digit BCD counter chain for the digital watch/timer datapath.
//   - Replaces hand-chained single-digit counters with one block.
//   - Features: up/down mode, per-digit limits, parallel load, synchronous re-init,
//     optional saturation at the end of the count range.
//   - Consumed by the stopwatch/countdown-timer display and control FSM.
// PARAMETERS
//   DIGITS    4        number of BCD digits; digit 0 is least significant
//   LIMITS    16'h5959 packed per-digit maximum, 4 bits per digit; each nibble is 1..9
//   INIT      16'h0000 packed per-digit re-init value; each nibble is <= its LIMITS nibble
//   SATURATE  0        0: wrap at the range ends; 1: hold at the range ends
// PORTS
//   clk         in   1          global clock, rising-edge
//   rst         in   1          asynchronous reset, active-high
//   clr         in   1          synchronous re-init to INIT (push-button reset)
//   load        in   1          synchronous parallel load of load_value
//   load_value  in   4*DIGITS   packed BCD load value
//   en          in   1          count tick; one step per cycle while high
//   up          in   1          1 = count up, 0 = count down; sampled with en
//   value       out  4*DIGITS   packed BCD counter value (registered)
//   at_zero     out  1          combinational; high when value == 0
//   at_max      out  1          combinational; high when value == LIMITS
//   carry_out   out  1          registered one-cycle pulse: up-count wrapped LIMITS -> 0
//   borrow_out  out  1          registered one-cycle pulse: down-count wrapped 0 -> LIMITS
//   expired     out  1          registered one-cycle pulse: down-count reached 0 from nonzero
// BEHAVIOUR
//   Reset
//   - rst high (async): value = INIT; carry_out = borrow_out = expired = 0.
//   - State is held while rst is high. Counting resumes on the first edge after release.
//   Priority per edge
//   - rst > clr > load > en.
//   - clr: value <= INIT.
//   - load: value <= load_value, with any nibble above its limit clamped to its LIMITS nibble.
//   - clr and load clear all three pulse outputs for that cycle.
//   Counting
//   - Applies only when en = 1 and neither clr nor load is active.
//   - Up: digit i increments when every lower digit j < i is at LIMITS[j].
//     A digit at its limit that steps goes to 0.
//   - Down: digit i decrements when every lower digit is 0.
//     A digit at 0 that steps goes to its LIMITS nibble.
//   - The whole chain steps in a single cycle; there is no per-digit pipeline delay.
//   Range ends, SATURATE = 0
//   - Up from value == LIMITS: value <= 0; carry_out = 1 in the next cycle.
//   - Down from value == 0: value <= LIMITS; borrow_out = 1 in the next cycle.
//   Range ends, SATURATE = 1
//   - Up at LIMITS or down at 0: value holds and no pulse is produced.
//   - The en tick is ignored; the counter stays stuck until clr or load.
//   expired
//   - Pulses for one cycle after a down-count edge that moves value from 1 to 0.
//   - Never produced by load, clr or reset landing on 0.
//   Pulse outputs
//   - Each pulse is high for exactly one cycle per event.
//   - Back-to-back events give back-to-back pulses.
//   Mode switching
//   - Changing up between cycles takes effect immediately; there is no hysteresis.
//   en = 0
//   - value holds; all pulse outputs are 0 next cycle.
// TESTING
//   1. rst pulse mid-count -> value = 16'h0000 immediately (async); all pulses 0;
//      counting resumes on the first edge after release.
//   2. Down, SATURATE=0, load 16'h0100, 3 en ticks -> 0059, 0058, 0057;
//      at 16'h0000, 1 tick -> 16'h5959 and borrow_out pulses once.
//   3. Up, SATURATE=0, from 16'h5958, 2 ticks -> 16'h5959, then 16'h0000;
//      carry_out pulses only after the second tick.
//   4. Down, SATURATE=1, from 16'h0002, 4 ticks -> 0001, 0000, 0000, 0000;
//      expired pulses exactly once; no borrow_out.
//   5. Load 16'h7A99 -> value = 16'h5959 (clamped).
//      clr, load and en together -> value = INIT; pulses 0.
//   6. Random en/up/load/clr for 10k cycles vs. an integer reference model
//      (mixed radix 10,6,10,6) -> every digit stays <= its limit and the pulses match.

Source files
------------

// File: rtl/bcd_updown_counter_chain.sv
// Multi-digit BCD up/down counter chain with per-digit limits, parallel load,
// synchronous re-init and optional saturation at the ends of the count range.
// Digit 0 is the least significant nibble of value_o.

module bcd_updown_counter_chain #(
   parameter int                  DIGITS   = 4,
   parameter logic [4*DIGITS-1:0] LIMITS   = 16'h5959,
   parameter logic [4*DIGITS-1:0] INIT     = 16'h0000,
   parameter bit                  SATURATE = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   load_value_i,
   input  logic                  en_i,
   input  logic                  up_i,
   output logic [4*DIGITS-1:0]   value_o,
   output logic                  at_zero_o,
   output logic                  at_max_o,
   output logic                  carry_out_o,
   output logic                  borrow_out_o,
   output logic                  expired_o
);

   localparam logic [4*DIGITS-1:0] ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

   logic [4*DIGITS-1:0] value_q, value_d;
   logic                carry_q, carry_d;
   logic                borrow_q, borrow_d;
   logic                expired_q, expired_d;

   logic [4*DIGITS-1:0] upValue;
   logic [4*DIGITS-1:0] downValue;
   logic [4*DIGITS-1:0] clampValue;
   logic                upRipple;
   logic                downRipple;
   logic                atZero;
   logic                atMax;

   assign atZero = (value_q == '0);
   assign atMax  = (value_q == LIMITS);

   // Whole-chain increment in one cycle: a digit steps only while every lower digit sits at its limit
   always_comb begin
      upValue  = value_q;
      upRipple = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (upRipple) begin
            upValue[4*i +: 4] = (value_q[4*i +: 4] == LIMITS[4*i +: 4]) ? 4'd0
                                                                         : value_q[4*i +: 4] + 4'd1;
         end
         upRipple = upRipple && (value_q[4*i +: 4] == LIMITS[4*i +: 4]);
      end
   end

   // Whole-chain decrement in one cycle: a digit steps only while every lower digit is zero
   always_comb begin
      downValue  = value_q;
      downRipple = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (downRipple) begin
            downValue[4*i +: 4] = (value_q[4*i +: 4] == 4'd0) ? LIMITS[4*i +: 4]
                                                               : value_q[4*i +: 4] - 4'd1;
         end
         downRipple = downRipple && (value_q[4*i +: 4] == 4'd0);
      end
   end

   // Load value with every out-of-range nibble pulled down to that digit's limit
   always_comb begin
      clampValue = load_value_i;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_value_i[4*i +: 4] > LIMITS[4*i +: 4]) begin
            clampValue[4*i +: 4] = LIMITS[4*i +: 4];
         end
      end
   end

   // Next value and pulse selection with clr > load > en priority; saturation swallows the end-of-range tick
   always_comb begin
      value_d   = value_q;
      carry_d   = 1'b0;
      borrow_d  = 1'b0;
      expired_d = 1'b0;
      if (clr_i) begin
         value_d = INIT;
      end else if (load_i) begin
         value_d = clampValue;
      end else if (en_i) begin
         if (up_i) begin
            if (!(SATURATE && atMax)) begin
               value_d = upValue;
               carry_d = atMax;
            end
         end else begin
            if (!(SATURATE && atZero)) begin
               value_d   = downValue;
               borrow_d  = atZero;
               expired_d = (value_q == ONE);
            end
         end
      end
   end

   // Counter and pulse registers; async reset returns to the re-init value
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         value_q   <= INIT;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         value_q   <= value_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         expired_q <= expired_d;
      end
   end

   assign value_o      = value_q;
   assign at_zero_o    = atZero;
   assign at_max_o     = atMax;
   assign carry_out_o  = carry_q;
   assign borrow_out_o = borrow_q;
   assign expired_o    = expired_q;

endmodule

// File: tb/tb_bcd_updown_counter_chain.sv
// Bench for bcd_updown_counter_chain: a wrapping and a saturating instance share
// one stimulus stream and are compared every cycle against a mixed-radix
// integer model (digits of radix 10,6,10,6, so the range is 0..3599).

module tb_bcd_updown_counter_chain;

   localparam int MAXN = 3599;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic [15:0] loadValue = 16'h0000;
   logic        en = 1'b0;
   logic        up = 1'b0;

   logic [15:0] valueW, valueS;
   logic        atZeroW, atZeroS, atMaxW, atMaxS;
   logic        carryW, carryS, borrowW, borrowS, expiredW, expiredS;

   int checks = 0;
   int failures = 0;

   int radix[4] = '{10, 6, 10, 6};

   // Model state per instance: index 0 wraps, index 1 saturates
   int n[2];
   bit expCarry[2];
   bit expBorrow[2];
   bit expExpired[2];

   bcd_updown_counter_chain #(.DIGITS(4), .LIMITS(16'h5959), .INIT(16'h0000), .SATURATE(1'b0)) dutWrap (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_value_i(loadValue),
      .en_i(en), .up_i(up), .value_o(valueW), .at_zero_o(atZeroW), .at_max_o(atMaxW),
      .carry_out_o(carryW), .borrow_out_o(borrowW), .expired_o(expiredW)
   );

   bcd_updown_counter_chain #(.DIGITS(4), .LIMITS(16'h5959), .INIT(16'h0000), .SATURATE(1'b1)) dutSat (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_value_i(loadValue),
      .en_i(en), .up_i(up), .value_o(valueS), .at_zero_o(atZeroS), .at_max_o(atMaxS),
      .carry_out_o(carryS), .borrow_out_o(borrowS), .expired_o(expiredS)
   );

   always #5 clk = ~clk;

   // Clamped BCD word to its position in the 0..3599 count range
   function automatic int bcdToInt(input logic [15:0] b);
      int acc = 0;
      int mult = 1;
      for (int i = 0; i < 4; i++) begin
         int nib = int'(b[4*i +: 4]);
         if (nib > radix[i] - 1) nib = radix[i] - 1;
         acc += nib * mult;
         mult *= radix[i];
      end
      return acc;
   endfunction

   function automatic logic [15:0] intToBcd(input int v);
      logic [15:0] r = '0;
      int rem = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(rem % radix[i]);
         rem = rem / radix[i];
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".wrap.value"},   valueW,          intToBcd(n[0]));
      checkOutput({tag, ".wrap.atZero"},  16'(atZeroW),    16'(n[0] == 0));
      checkOutput({tag, ".wrap.atMax"},   16'(atMaxW),     16'(n[0] == MAXN));
      checkOutput({tag, ".wrap.carry"},   16'(carryW),     16'(expCarry[0]));
      checkOutput({tag, ".wrap.borrow"},  16'(borrowW),    16'(expBorrow[0]));
      checkOutput({tag, ".wrap.expired"}, 16'(expiredW),   16'(expExpired[0]));
      checkOutput({tag, ".sat.value"},    valueS,          intToBcd(n[1]));
      checkOutput({tag, ".sat.atZero"},   16'(atZeroS),    16'(n[1] == 0));
      checkOutput({tag, ".sat.atMax"},    16'(atMaxS),     16'(n[1] == MAXN));
      checkOutput({tag, ".sat.carry"},    16'(carryS),     16'(expCarry[1]));
      checkOutput({tag, ".sat.borrow"},   16'(borrowS),    16'(expBorrow[1]));
      checkOutput({tag, ".sat.expired"},  16'(expiredS),   16'(expExpired[1]));
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         n[k] = 0;
         expCarry[k] = 1'b0;
         expBorrow[k] = 1'b0;
         expExpired[k] = 1'b0;
      end
   endtask

   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         bit sat = (k == 1);
         expCarry[k] = 1'b0;
         expBorrow[k] = 1'b0;
         expExpired[k] = 1'b0;
         if (clr) begin
            n[k] = 0;
         end else if (load) begin
            n[k] = bcdToInt(loadValue);
         end else if (en) begin
            if (up) begin
               if (n[k] == MAXN) begin
                  if (!sat) begin
                     n[k] = 0;
                     expCarry[k] = 1'b1;
                  end
               end else begin
                  n[k] = n[k] + 1;
               end
            end else begin
               if (n[k] == 0) begin
                  if (!sat) begin
                     n[k] = MAXN;
                     expBorrow[k] = 1'b1;
                  end
               end else begin
                  if (n[k] == 1) expExpired[k] = 1'b1;
                  n[k] = n[k] - 1;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit c, input bit l, input logic [15:0] lv,
                                input bit e, input bit u, input string tag);
      clr = c;
      load = l;
      loadValue = lv;
      en = e;
      up = u;
      @(posedge clk);
      modelStep();
      #1;
      checkAll(tag);
   endtask

   // Asynchronous reset asserted between edges, held across one edge, then released
   task automatic pulseReset(input string tag);
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      checkAll({tag, ".async"});
      en = 1'b1;
      up = 1'b1;
      @(posedge clk);
      #1;
      checkAll({tag, ".hold"});
      rst = 1'b0;
   endtask

   initial begin
      bit dir;
      modelReset();
      #1;
      checkAll("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Count up a little, then reset mid-count; counting resumes on the next edge
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 16'h0, 1, 1, "preRst");
      checkOutput("preRst.const", valueW, 16'h0005);
      pulseReset("midRst");
      applyStimulus(0, 0, 16'h0, 1, 1, "resume");
      checkOutput("resume.const", valueW, 16'h0001);

      // Down count across a digit boundary, then wrap below zero
      applyStimulus(0, 1, 16'h0100, 0, 0, "ld0100");
      applyStimulus(0, 0, 16'h0, 1, 0, "dn1");
      checkOutput("dn1.const", valueW, 16'h0059);
      applyStimulus(0, 0, 16'h0, 1, 0, "dn2");
      checkOutput("dn2.const", valueW, 16'h0058);
      applyStimulus(0, 0, 16'h0, 1, 0, "dn3");
      checkOutput("dn3.const", valueW, 16'h0057);
      applyStimulus(0, 1, 16'h0000, 0, 0, "ld0000");
      applyStimulus(0, 0, 16'h0, 1, 0, "dnWrap");
      checkOutput("dnWrap.const", valueW, 16'h5959);
      checkOutput("dnWrap.borrow", 16'(borrowW), 16'h0001);
      applyStimulus(0, 0, 16'h0, 0, 0, "idle");

      // Up count to the limit then wrap with a single carry pulse
      applyStimulus(0, 1, 16'h5958, 0, 1, "ld5958");
      applyStimulus(0, 0, 16'h0, 1, 1, "up1");
      checkOutput("up1.carry", 16'(carryW), 16'h0000);
      applyStimulus(0, 0, 16'h0, 1, 1, "up2");
      checkOutput("up2.const", valueW, 16'h0000);
      checkOutput("up2.carry", 16'(carryW), 16'h0001);
      applyStimulus(0, 0, 16'h0, 1, 1, "up3");

      // Saturating down count reaching zero
      applyStimulus(0, 1, 16'h0002, 0, 0, "ld0002");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0, 1, 0, "satDn");
      checkOutput("satDn.const", valueS, 16'h0000);

      // Load clamping and priority of clr over load and en
      applyStimulus(0, 1, 16'h7A99, 1, 1, "ldClamp");
      checkOutput("ldClamp.const", valueW, 16'h5959);
      applyStimulus(0, 0, 16'h0, 1, 1, "satUp");
      checkOutput("satUp.const", valueS, 16'h5959);
      applyStimulus(1, 1, 16'h1234, 1, 1, "clrPrio");
      checkOutput("clrPrio.const", valueW, 16'h0000);

      // Random traffic with biased load values to reach the range ends often
      dir = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         int r = $urandom_range(0, 99);
         int sel = $urandom_range(0, 5);
         logic [15:0] lv;
         case (sel)
            0: lv = 16'h0001;
            1: lv = 16'h5959;
            2: lv = 16'h5958;
            3: lv = 16'h0000;
            default: lv = 16'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         if (c == 5000) pulseReset("rndRst");
         applyStimulus(r < 2, (r >= 2) && (r < 8), lv, $urandom_range(0, 99) < 85, dir, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
